tdc_readout: RTL
================

# tdc_readout

Downstream stage of the TinyTapeout TDC top level. It takes the thermometer word latched by the delay-line stop flops and converts it to a bubble-tolerant binary code using a population count. Results are buffered in a small FIFO and presented as a show-ahead byte stream. The top level maps that stream onto `uo_out` / `uio` and pops it from the pins.

## Interface
Parameters:
- `N_DELAY`, 32, delay-line taps (thermometer width); 2..127
- `CNT_W`, `$clog2(N_DELAY+1)`, width of the code; must be ≤ 7
- `FIFO_DEPTH`, 4, result entries; power of two ≥ 2

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `therm_i`  in  N_DELAY  thermometer word from the stop flops; stable whenever `meas_valid_i`=1
- `meas_valid_i`  in  1  one-cycle pulse per measurement, `clk` domain; back-to-back pulses allowed
- `rd_i`  in  1  pop the head entry; ignored when `valid_o`=0
- `clear_i`  in  1  synchronous clear of `overflow_o`
- `data_o`  out  8  head result byte
- `valid_o`  out  1  FIFO not empty
- `overflow_o`  out  1  sticky; a result was dropped

## Operation
- Stage 1 (S1): on `meas_valid_i`=1, register `therm_i` and set `s1_vld`; otherwise `s1_vld`=0.
- Stage 2 (S2): `code` = popcount(S1 word), range 0..N_DELAY. Popcount is used so that bubbles in the thermometer word are tolerated. Register `code` and `s2_vld`.
- Result byte: bit7 = `sat` (`code`==N_DELAY); bits6:0 = `code` zero-extended.
- FIFO write: when `s2_vld`=1.
- FIFO read: when `rd_i`=1 and not empty. Entries are kept in order.
- Show-ahead: `data_o` = head entry while `valid_o`=1, and 0x00 while empty.
- Full, write without read: the new result is dropped and `overflow_o` is set to 1.
- Full, write and read in the same cycle: both happen, nothing is dropped, `overflow_o` is unchanged.
- Empty, `rd_i`=1: no effect. If an S2 write lands in the same cycle, it is written and not popped.
- `clear_i`=1 clears `overflow_o`. If a drop happens in the same cycle, the drop wins and `overflow_o`=1.
- No FSM beyond the pipeline valids and the FIFO pointers. Occupancy is tracked with pointers that are one bit wider than the address, so they wrap cleanly.

## Timing
- Reset (asynchronous assertion, synchronous release):
  - S1/S2 valids = 0, pointers = 0, so `valid_o`=0
  - `data_o`=0x00, `overflow_o`=0
  - Pipeline contents and stored entries are discarded immediately.
- Latency: `meas_valid_i` sampled high at edge n gives `valid_o`=1 after edge n+2, provided the FIFO was empty.
- Throughput: one measurement per cycle.
- Pop: `rd_i` sampled at edge k; the next entry (or empty) is visible after edge k.
- `overflow_o` updates one edge after the dropping write.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- Package `tdc_pkg` holds:
  - `N_DELAY_DEF`
  - the `SAT_BIT`=7 constant
  - a `popcount` function parameterised by width
- Sub-module `tdc_result_fifo`: synchronous show-ahead FIFO. It has `wr`/`rd`/`full`/`empty` ports, 8-bit data and a `DEPTH` parameter. It is instantiated once.
- `tdc_readout` contains S1, S2, byte packing and the overflow flag.

## Test plan
- Reset and basic measurement:
  - Assert `rst` → `valid_o`=0, `data_o`=0x00, `overflow_o`=0.
  - Pulse with `therm_i`=0x0000_00FF → `valid_o`=1 two cycles later with `data_o`=0x08.
  - `rd_i` → `valid_o`=0, `data_o`=0x00.
- Bubble tolerance: `therm_i`=0x0000_01F7 (8 ones) → `data_o`=0x08.
- Extremes:
  - `therm_i`=0x0000_0000 → `data_o`=0x00, `valid_o`=1.
  - `therm_i`=0xFFFF_FFFF → `data_o`=0xA0 (`sat` set, `code`=32).
- Overflow:
  - Five back-to-back pulses with codes 1, 2, 3, 4, 5 and no reads → pops return 0x01, 0x02, 0x03, 0x04; `overflow_o`=1.
  - `clear_i` → `overflow_o`=0.
- Full with simultaneous traffic: fill to 4 entries, then assert `rd_i` in the same cycle as an S2 write → no drop, `overflow_o`=0, occupancy stays 4, order preserved.
- Reset mid-operation: assert `rst` with S1, S2 and the FIFO all occupied → outputs are reset values at once; after release no stale entry appears.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the TDC readout path.
//   N_DELAY_DEF : default delay-line tap count
//   SAT_BIT     : bit of the result byte that flags a saturated code
//   popcount    : number of set bits in the low 'width' bits of a word
package tdc_pkg;

  localparam int unsigned N_DELAY_DEF = 32;
  localparam int unsigned SAT_BIT     = 7;
  localparam int unsigned POP_MAX_W   = 128;

  // Callers zero-extend their word to POP_MAX_W and pass the real width.
  function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] word,
                                          input int unsigned         width);
    logic [7:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (i < width && word[i]) cnt = cnt + 8'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tdc_readout_if.sv
// Measurement and result-stream bundle of the TDC readout.
//   therm_i/meas_valid_i : thermometer word and its one-cycle strobe
//   rd_i/clear_i         : pop head entry / clear the overflow flag
//   data_o/valid_o       : show-ahead head byte and not-empty flag
//   overflow_o           : sticky "result dropped" flag
// master = the side producing measurements and consuming results,
// slave  = tdc_readout.
interface tdc_readout_if #(
  parameter int unsigned N_DELAY = tdc_pkg::N_DELAY_DEF
);
  logic [N_DELAY-1:0] therm_i;
  logic               meas_valid_i;
  logic               rd_i;
  logic               clear_i;
  logic [7:0]         data_o;
  logic               valid_o;
  logic               overflow_o;

  modport master (
    output therm_i, meas_valid_i, rd_i, clear_i,
    input  data_o, valid_o, overflow_o
  );

  modport slave (
    input  therm_i, meas_valid_i, rd_i, clear_i,
    output data_o, valid_o, overflow_o
  );
endinterface

// File: rtl/tdc_result_fifo.sv
// Synchronous show-ahead FIFO for 8-bit result bytes.
//   clk, rst : clock, asynchronous active-high reset
//   wr, din  : write request and data; accepted unless full (or full with a pop)
//   rd       : pop head; ignored while empty
//   dout     : head entry, 0x00 while empty
//   full, empty : occupancy flags
module tdc_result_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_rd;
  logic        do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr = wr && (!full || do_rd);
  assign dout  = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/tdc_readout.sv
// Thermometer-to-binary readout of the TDC delay line.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tdc_readout_if slave (measurement in, show-ahead byte stream out)
// S1 captures the thermometer word, S2 registers its popcount (bubble
// tolerant), and the packed byte {sat, code} is queued in a small FIFO.
module tdc_readout
  import tdc_pkg::*;
#(
  parameter int unsigned N_DELAY    = N_DELAY_DEF,
  parameter int unsigned CNT_W      = $clog2(N_DELAY + 1),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdc_readout_if.slave bus
);

  logic [N_DELAY-1:0] s1_word;
  logic               s1_vld;
  logic [CNT_W-1:0]   s2_code;
  logic               s2_vld;
  logic [CNT_W-1:0]   code_next;
  logic [7:0]         result;
  logic               full;
  logic               empty;
  logic               drop;
  logic               overflow;

  assign code_next = CNT_W'(popcount(POP_MAX_W'(s1_word), N_DELAY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_word <= '0;
      s2_vld  <= 1'b0;
      s2_code <= '0;
    end else begin
      s1_vld <= bus.meas_valid_i;
      if (bus.meas_valid_i) s1_word <= bus.therm_i;
      s2_vld <= s1_vld;
      if (s1_vld) s2_code <= code_next;
    end
  end

  always_comb begin
    result          = '0;
    result[6:0]     = 7'(s2_code);
    result[SAT_BIT] = (s2_code == CNT_W'(N_DELAY));
  end

  tdc_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (s2_vld),
    .rd    (bus.rd_i),
    .din   (result),
    .dout  (bus.data_o),
    .full  (full),
    .empty (empty)
  );

  // Full implies non-empty, so a concurrent rd_i always makes room.
  assign drop = s2_vld && full && !bus.rd_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overflow <= 1'b0;
    else if (drop)        overflow <= 1'b1;
    else if (bus.clear_i) overflow <= 1'b0;
  end

  assign bus.valid_o    = !empty;
  assign bus.overflow_o = overflow;

endmodule
